// File: rtl/limb_pkg.sv
// Types and constants shared by the fetch front end and its tests.
package limb_pkg;

    localparam int WORD_W = 32;
    localparam int FETCH_ADDR_W = 32;

    // Condition field "always", used as the top nibble of test instruction words.
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [WORD_W-1:0]       instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetched {instr, pc} entries; a flush empties it and beats a same-cycle push.
module fetch_queue
    import limb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0);
    assign head    = slots[rd_ptr];

    // NOTE: the storage array has no reset; count decides validity, so stale slots are never consumed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        do_push |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word addresses to a 1-cycle synchronous RAM, tags returning words with their
// PC and buffers them in a prefetch queue presented to decode over valid/ready.
module instruction_fetch_unit
    import limb_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rw,
    input  logic [31:0]       mem_dout,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_pc;
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    inflight;
    logic              issue;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign mem_rw = 1'b0;

    // Credit counts every word already owed a slot; a same-cycle pop is deliberately not credited.
    assign inflight = {1'b0, count} + (CNT_W + 1)'(s1_valid) + (CNT_W + 1)'(s2_valid);
    assign issue    = inflight < (CNT_W + 1)'(DEPTH);

    assign pop        = instr_valid && instr_ready;
    assign push_entry = '{instr: mem_dout, pc: s2_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            mem_a    <= RESET_PC;
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s2_valid <= 1'b0;
            s2_pc    <= '0;
        end else begin
            s2_pc <= s1_pc;
            if (branch_valid) begin
                // The target is issued on the redirect edge; the word already at the RAM is killed.
                pc       <= branch_target + 1'b1;
                mem_a    <= branch_target;
                s1_valid <= 1'b1;
                s1_pc    <= branch_target;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                s1_valid <= issue;
                if (issue) begin
                    pc    <= pc + 1'b1;
                    mem_a <= pc;
                    s1_pc <= pc;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (s2_valid),
        .pop     (pop),
        .flush   (branch_valid),
        .wr_entry(push_entry),
        .head    (head),
        .count   (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

endmodule
